// File: rtl/alu_uop_sequencer.sv
// Registered ALU-control decode with valid/ready on both sides. Shifts larger than
// MAX_STEP are issued as several shift micro-ops, MAX_STEP bits at a time.
module alu_uop_sequencer #(
  parameter int W        = 16,
  parameter int MAX_STEP = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [3:0]   i_op_in,
  input  logic [W-1:0] i_b_in,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [2:0]   o_alu_op,
  output logic [W-1:0] o_alu_b,
  output logic         o_out_last
);
  localparam int SHAMT_W = $clog2(W);
  localparam logic [SHAMT_W-1:0] STEP_MAX = SHAMT_W'(MAX_STEP);

  localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd2, OP_ADD = 3'd4,
                         OP_SUB = 3'd5, OP_SHIFT = 3'd6, OP_SLT = 3'd7;
  localparam logic [2:0] DIR_SLL = 3'b000, DIR_SRL = 3'b110, DIR_SRA = 3'b100;

  typedef enum logic [1:0] {IDLE, HOLD, SPLIT} state_t;

  state_t               r_state;
  logic                 r_valid, r_last;
  logic [2:0]           r_alu_op, r_dir;
  logic [W-1:0]         r_alu_b;
  logic [SHAMT_W-1:0]   r_rem;

  logic                 w_accept, w_is_shift;
  logic [2:0]           w_op, w_dir;
  logic [SHAMT_W-1:0]   w_amt, w_rem_step, w_rem_next;

  // Shift micro-op operand: direction code just above the step amount, all else zero.
  function automatic logic [W-1:0] shape(input logic [2:0] dir, input logic [SHAMT_W-1:0] step);
    logic [W-1:0] b;
    b = '0;
    b[SHAMT_W-1:0]       = step;
    b[SHAMT_W+2:SHAMT_W] = dir;
    return b;
  endfunction

  always_comb begin
    w_op       = OP_ADD;
    w_dir      = DIR_SLL;
    w_is_shift = 1'b0;
    case (i_op_in)
      4'd2:                w_op = OP_AND;
      4'd3, 4'd4, 4'd14:   w_op = OP_SUB;
      4'd7, 4'd9:          w_op = OP_OR;
      4'd10:               w_op = OP_SLT;
      4'd11: begin w_op = OP_SHIFT; w_is_shift = 1'b1; w_dir = DIR_SLL; end
      4'd12: begin w_op = OP_SHIFT; w_is_shift = 1'b1; w_dir = DIR_SRL; end
      4'd13: begin w_op = OP_SHIFT; w_is_shift = 1'b1; w_dir = DIR_SRA; end
      default:             w_op = OP_ADD;
    endcase
  end

  assign w_amt      = i_b_in[SHAMT_W-1:0];
  assign w_rem_step = (r_rem > STEP_MAX) ? STEP_MAX : r_rem;
  assign w_rem_next = r_rem - w_rem_step;
  assign o_in_ready = (r_state == IDLE) | ((r_state == HOLD) & i_out_ready);
  assign w_accept   = i_in_valid & o_in_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_alu_op <= '0;
      r_alu_b  <= '0;
      r_last   <= 1'b0;
      r_rem    <= '0;
      r_dir    <= '0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_alu_op <= w_op;
      r_dir    <= w_dir;
      if (w_is_shift && (w_amt > STEP_MAX)) begin
        r_alu_b <= shape(w_dir, STEP_MAX);
        r_rem   <= w_amt - STEP_MAX;
        r_last  <= 1'b0;
        r_state <= SPLIT;
      end else begin
        r_alu_b <= w_is_shift ? shape(w_dir, w_amt) : i_b_in;
        r_rem   <= '0;
        r_last  <= 1'b1;
        r_state <= HOLD;
      end
    end else if (i_out_ready) begin
      case (r_state)
        HOLD: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
        SPLIT: begin
          r_alu_b <= shape(r_dir, w_rem_step);
          r_rem   <= w_rem_next;
          if (w_rem_next == '0) begin
            r_last  <= 1'b1;
            r_state <= HOLD;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out_valid = r_valid;
  assign o_alu_op    = r_alu_op;
  assign o_alu_b     = r_alu_b;
  assign o_out_last  = r_last;
endmodule
